// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ctrl_if
//  Description : Bundle between the core's memory stage (master) and the
//                word-organised data memory controller (slave).
//                  request    - access request, held by the master until valid
//                  we_re      - 1 = store, 0 = load
//                  mask       - byte-lane enables for stores
//                  address    - byte address
//                  store_data - lane-aligned store data
//                  valid      - one-cycle response strobe
//                  load_data  - read word, held between load responses
//                  error      - misaligned-access flag (MEM_ALIGN_CHECK_EN only)
//  Options     : MEM_ALIGN_CHECK_EN adds the error signal.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_ctrl_if;
  logic        request;
  logic        we_re;
  logic [3:0]  mask;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        valid;
  logic [31:0] load_data;
`ifdef MEM_ALIGN_CHECK_EN
  logic        error;

  modport master (
    output request, we_re, mask, address, store_data,
    input  valid, load_data, error
  );

  modport slave (
    input  request, we_re, mask, address, store_data,
    output valid, load_data, error
  );
`else
  modport master (
    output request, we_re, mask, address, store_data,
    input  valid, load_data
  );

  modport slave (
    input  request, we_re, mask, address, store_data,
    output valid, load_data
  );
`endif
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ctrl
//  Description : Word-organised data memory with a wait-state handshake.
//                An accepted request is latched, held for WAIT_CYCLES stall
//                cycles, committed on the edge entering RESP and answered
//                with a one-cycle valid strobe. Loads return the full word.
//  Ports       : clk    - single clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - data_mem_ctrl_if.slave (request/we_re/mask/address/
//                         store_data in; valid/load_data[/error] out)
//  Parameters  : DEPTH_WORDS - storage words, power of two
//                WAIT_CYCLES - stall cycles between acceptance and response
//  Options     : MEM_ALIGN_CHECK_EN - flag and suppress misaligned accesses
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  data_mem_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  // FSM state
  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  // Set on the first edge after reset release; blocks acceptance (and so any
  // commit) while reset is asserted without feeding rst_n into data logic.
  logic             run_q;

  // Latched access
  logic             we_q;
  logic [3:0]       mask_q;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       lsb_q;
  logic [31:0]      wdata_q;

  // Registered outputs
  logic             valid_q;
  logic [31:0]      load_data_q;

  // FSM outputs
  logic             w_latch;
  logic             w_commit;

  // Effective access: straight from the bus on the accepting edge (needed
  // when WAIT_CYCLES==0 commits on that same edge), latched copy otherwise.
  logic             w_acc_we;
  logic [3:0]       w_acc_mask;
  logic [IDX_W-1:0] w_acc_idx;
  logic [1:0]       w_acc_lsb;
  logic [31:0]      w_acc_wdata;
  logic             w_reject;
  logic [31:0]      w_rd_word;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.request && run_q) begin
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        // A request seen here is ignored; it is sampled again in IDLE.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_latch  = 1'b0;
    w_commit = 1'b0;
    case (state_q)
      S_IDLE: begin
        w_latch  = bus.request && run_q;
        w_commit = bus.request && run_q && (WAIT_CYCLES == 0);
      end
      S_WAIT: begin
        w_commit = (cnt_q == 4'd0);
      end
      default: begin
        w_latch  = 1'b0;
        w_commit = 1'b0;
      end
    endcase
  end

  assign w_acc_we    = (state_q == S_IDLE) ? bus.we_re                   : we_q;
  assign w_acc_mask  = (state_q == S_IDLE) ? bus.mask                    : mask_q;
  assign w_acc_idx   = (state_q == S_IDLE) ? bus.address[2 +: IDX_W]     : idx_q;
  assign w_acc_lsb   = (state_q == S_IDLE) ? bus.address[1:0]            : lsb_q;
  assign w_acc_wdata = (state_q == S_IDLE) ? bus.store_data              : wdata_q;

  // --------------------------------------------------------------------------
  // Request latch and registered response
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      mask_q      <= 4'd0;
      idx_q       <= '0;
      lsb_q       <= 2'd0;
      wdata_q     <= 32'd0;
      valid_q     <= 1'b0;
      load_data_q <= 32'd0;
    end else begin
      if (w_latch) begin
        we_q    <= bus.we_re;
        mask_q  <= bus.mask;
        idx_q   <= bus.address[2 +: IDX_W];
        lsb_q   <= bus.address[1:0];
        wdata_q <= bus.store_data;
      end
      valid_q <= w_commit;
      if (w_commit && !w_acc_we && !w_reject) begin
        load_data_q <= w_rd_word;
      end
    end
  end

  assign bus.valid     = valid_q;
  assign bus.load_data = load_data_q;

  // --------------------------------------------------------------------------
  // Storage: one byte array per lane so each lane has its own write enable.
  // Not reset; contents survive rst_n.
  // --------------------------------------------------------------------------
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (w_commit && w_acc_we && w_acc_mask[l] && !w_reject) begin
        mem_q[w_acc_idx] <= w_acc_wdata[8*l +: 8];
      end
    end

    assign w_rd_word[8*l +: 8] = mem_q[w_acc_idx];
  end

  // --------------------------------------------------------------------------
  // Alignment check
  // --------------------------------------------------------------------------
`ifdef MEM_ALIGN_CHECK_EN
  logic error_q;
  logic w_unused;

  // Loads are full-word; stores are checked against the mask's natural size.
  always_comb begin
    w_reject = 1'b0;
    if (!w_acc_we) begin
      w_reject = (w_acc_lsb != 2'b00);
    end else begin
      case (w_acc_mask)
        4'b1111:          w_reject = (w_acc_lsb != 2'b00);
        4'b0011, 4'b1100: w_reject = w_acc_lsb[0];
        default:          w_reject = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else begin
      error_q <= w_commit && w_reject;
    end
  end

  assign bus.error = error_q;
  assign w_unused  = ^bus.address[31:2+IDX_W];
`else
  logic w_unused;

  assign w_reject = 1'b0;
  // Byte offset and bits above the index play no part without the check.
  assign w_unused = ^{w_acc_lsb, bus.address[31:2+IDX_W]};
`endif

endmodule
`default_nettype wire
